mdclcg_stream_ctrl: RTL and testbench

//  Sequencer and output packer for the modified dual-CLCG bit generator core.
//  - Accepts a seed set on a valid/ready handshake and drives the core's start and seed inputs.
//  - Discards a warm-up run of output bits, then packs the core's 1-bit/cycle output Zi into

---
 rtl/mdclcg_pkg.sv | 27 ++
 rtl/mdclcg_out_fifo.sv | 75 +++++++
 rtl/mdclcg_stream_ctrl.sv | 148 ++++++++++++++
 tb/tb_mdclcg_stream_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mdclcg_pkg.sv
// Shared definitions for the modified dual-CLCG generator: sequencer states,
// LCG constants and default seeds used by the core and its stream controller.
package mdclcg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEED   = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } state_e;

    // Multipliers and increments for LCG1..LCG4
    localparam logic [31:0] LCG_A1 = 32'd1664525;
    localparam logic [31:0] LCG_A2 = 32'd22695477;
    localparam logic [31:0] LCG_A3 = 32'd1103515245;
    localparam logic [31:0] LCG_A4 = 32'd134775813;
    localparam logic [31:0] LCG_B1 = 32'd1013904223;
    localparam logic [31:0] LCG_B2 = 32'd1;
    localparam logic [31:0] LCG_B3 = 32'd12345;
    localparam logic [31:0] LCG_B4 = 32'd2531011;

    localparam logic [31:0] DEF_SEED_X0 = 32'h1234_5678;
    localparam logic [31:0] DEF_SEED_Y0 = 32'h9ABC_DEF1;
    localparam logic [31:0] DEF_SEED_P0 = 32'h0F1E_2D3C;
    localparam logic [31:0] DEF_SEED_Q0 = 32'h4B5A_6978;

endpackage

// File: rtl/mdclcg_out_fifo.sv
// Two-entry in-order output buffer; the head entry is a register so the
// consumer sees a stable word that holds while it stalls.
module mdclcg_out_fifo
    import mdclcg_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] head,
    output logic              valid,
    output logic              full
);

    logic [WORD_W-1:0] head_r;
    logic [WORD_W-1:0] tail_r;
    logic [1:0]        count_r;

    // Status and head word straight from registers
    always_comb begin
        head  = head_r;
        valid = (count_r != 2'd0);
        full  = (count_r == 2'd2);
    end

    // Occupancy and storage update; a pop frees the head so a same-cycle push lands
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else if (flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else begin
            case (count_r)
                2'd0: begin
                    if (push) begin
                        head_r  <= din;
                        count_r <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_r <= din;
                    end else if (push) begin
                        tail_r  <= din;
                        count_r <= 2'd2;
                    end else if (pop) begin
                        count_r <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_r <= tail_r;
                        if (push) begin
                            tail_r <= din;
                        end else begin
                            count_r <= 2'd1;
                        end
                    end
                end
                default: begin
                    count_r <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mdclcg_stream_ctrl.sv
// Sequencer for the dual-CLCG core: seeds it, discards warm-up bits, packs the
// 1-bit/cycle output into words and streams them through a 2-entry buffer.
module mdclcg_stream_ctrl
    import mdclcg_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int WARMUP = 64,
    parameter int OVF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_valid,
    output logic              seed_ready,
    input  logic [31:0]       seed_x0,
    input  logic [31:0]       seed_y0,
    input  logic [31:0]       seed_p0,
    input  logic [31:0]       seed_q0,
    input  logic              stop,
    input  logic              run_en,
    output logic              core_start,
    output logic [31:0]       core_x0,
    output logic [31:0]       core_y0,
    output logic [31:0]       core_p0,
    output logic [31:0]       core_q0,
    input  logic              core_zi,
    output logic [WORD_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              busy,
    output logic [OVF_W-1:0]  ovf_count
);

    localparam int BC_W = $clog2(WORD_W);
    localparam int WC_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    state_e            state_r;
    logic [BC_W-1:0]   bitcnt_r;
    logic [WC_W-1:0]   wcnt_r;
    logic [WORD_W-2:0] sr_r;

    logic [WORD_W-1:0] word_s;
    logic              sample_s;
    logic              word_done_s;
    logic              pop_s;
    logic              flush_s;
    logic              drop_s;
    logic              fifo_full_s;

    // Sampling, word completion and buffer control; stop outranks completion
    always_comb begin
        sample_s    = 1'b0;
        word_done_s = 1'b0;
        word_s      = {sr_r, core_zi};
        pop_s       = rnd_ready && rnd_valid;
        flush_s     = stop && (state_r != ST_IDLE);
        sample_s    = (state_r == ST_RUN) && run_en && !stop;
        word_done_s = sample_s && (bitcnt_r == BC_W'(WORD_W - 1));
        drop_s      = word_done_s && fifo_full_s && !pop_s;
    end

    // Sequencer FSM with registered core controls, packer and drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            core_start <= 1'b1;
            seed_ready <= 1'b1;
            busy       <= 1'b0;
            core_x0    <= '0;
            core_y0    <= '0;
            core_p0    <= '0;
            core_q0    <= '0;
            wcnt_r     <= '0;
            bitcnt_r   <= '0;
            sr_r       <= '0;
            ovf_count  <= '0;
        end else begin
            if (drop_s && (ovf_count != {OVF_W{1'b1}})) begin
                ovf_count <= ovf_count + OVF_W'(1);
            end
            if (flush_s) begin
                state_r    <= ST_IDLE;
                core_start <= 1'b1;
                seed_ready <= 1'b1;
                busy       <= 1'b0;
                wcnt_r     <= '0;
                bitcnt_r   <= '0;
                sr_r       <= '0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (seed_valid) begin
                            core_x0    <= seed_x0;
                            core_y0    <= seed_y0;
                            core_p0    <= seed_p0;
                            core_q0    <= seed_q0;
                            seed_ready <= 1'b0;
                            busy       <= 1'b1;
                            state_r    <= ST_SEED;
                        end
                    end
                    ST_SEED: begin
                        core_start <= 1'b0;
                        wcnt_r     <= '0;
                        state_r    <= (WARMUP == 0) ? ST_RUN : ST_WARMUP;
                    end
                    ST_WARMUP: begin
                        if (wcnt_r == WC_W'(WARMUP - 1)) begin
                            state_r <= ST_RUN;
                        end else begin
                            wcnt_r <= wcnt_r + WC_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (sample_s) begin
                            sr_r <= word_s[WORD_W-2:0];
                            if (word_done_s) begin
                                bitcnt_r <= '0;
                            end else begin
                                bitcnt_r <= bitcnt_r + BC_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        core_start <= 1'b1;
                        seed_ready <= 1'b1;
                        busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

    mdclcg_out_fifo #(
        .WORD_W (WORD_W)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_s),
        .push  (word_done_s),
        .pop   (pop_s),
        .din   (word_s),
        .head  (rnd_data),
        .valid (rnd_valid),
        .full  (fifo_full_s)
    );

endmodule

// File: tb/tb_mdclcg_stream_ctrl.sv
// Directed bench for mdclcg_stream_ctrl with WORD_W=8, WARMUP=4, OVF_W=4;
// core_zi is driven from hand-written bit patterns.
module tb_mdclcg_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_valid;
    logic        seed_ready;
    logic [31:0] seed_x0, seed_y0, seed_p0, seed_q0;
    logic        stop;
    logic        run_en;
    logic        core_start;
    logic [31:0] core_x0, core_y0, core_p0, core_q0;
    logic        core_zi;
    logic [7:0]  rnd_data;
    logic        rnd_valid;
    logic        rnd_ready;
    logic        busy;
    logic [3:0]  ovf_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdclcg_stream_ctrl #(
        .WORD_W (8),
        .WARMUP (4),
        .OVF_W  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .seed_x0    (seed_x0),
        .seed_y0    (seed_y0),
        .seed_p0    (seed_p0),
        .seed_q0    (seed_q0),
        .stop       (stop),
        .run_en     (run_en),
        .core_start (core_start),
        .core_x0    (core_x0),
        .core_y0    (core_y0),
        .core_p0    (core_p0),
        .core_q0    (core_q0),
        .core_zi    (core_zi),
        .rnd_data   (rnd_data),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .busy       (busy),
        .ovf_count  (ovf_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive the top n bits of w, MSB first, one per cycle with run_en=1
    task automatic send_bits(input logic [7:0] w, input int n);
        run_en = 1'b1;
        for (int i = 7; i > 7 - n; i--) begin
            core_zi = w[i];
            step();
        end
    endtask

    // Seed handshake, then walk to the first RUN cycle (T+6) checking latency
    task automatic seed_and_warm(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [31:0] d, input string tag);
        seed_x0 = a; seed_y0 = b; seed_p0 = c; seed_q0 = d;
        seed_valid = 1'b1;
        step();
        seed_valid = 1'b0;
        check({tag, "_start_t1"}, core_start, 1);
        check({tag, "_sready_t1"}, seed_ready, 0);
        check({tag, "_busy_t1"}, busy, 1);
        check({tag, "_seeds"}, {core_x0, core_y0}, {a, b});
        check({tag, "_seeds2"}, {core_p0, core_q0}, {c, d});
        step();
        check({tag, "_start_t2"}, core_start, 0);
        repeat (4) step();
    endtask

    initial begin
        rst = 1'b1; seed_valid = 1'b0; stop = 1'b0; run_en = 1'b0;
        core_zi = 1'b0; rnd_ready = 1'b0;
        seed_x0 = '0; seed_y0 = '0; seed_p0 = '0; seed_q0 = '0;
        step();
        step();
        rst = 1'b0;

        // Test 1: reset values, seed and first word
        check("rst_start", core_start, 1);
        check("rst_sready", seed_ready, 1);
        check("rst_valid", rnd_valid, 0);
        check("rst_data", rnd_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf_count, 0);
        check("rst_seed", core_x0, 0);
        seed_and_warm(32'd1, 32'd2, 32'd3, 32'd4, "t1");
        send_bits(8'hB2, 7);
        check("t1_valid_t13", rnd_valid, 0);
        send_bits(8'h02, 1);
        check("t1_valid_t14", rnd_valid, 1);
        check("t1_data", rnd_data, 8'hB2);

        // Test 2: stall consumer, third word dropped, then drain in order
        send_bits(8'h5C, 8);
        check("t2_hold_b2", rnd_data, 8'hB2);
        check("t2_ovf0", ovf_count, 0);
        send_bits(8'hFF, 8);
        check("t2_ovf1", ovf_count, 1);
        check("t2_head", rnd_data, 8'hB2);
        run_en = 1'b0;
        rnd_ready = 1'b1;
        step();
        check("t2_second", rnd_data, 8'h5C);
        check("t2_second_v", rnd_valid, 1);
        step();
        check("t2_empty", rnd_valid, 0);
        rnd_ready = 1'b0;
        check("t2_ovf_keep", ovf_count, 1);

        // Test 3: pause collection mid-word
        send_bits(8'hA0, 3);
        run_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            core_zi = i[0];
            step();
        end
        check("t3_no_word", rnd_valid, 0);
        send_bits(8'h90, 5);
        check("t3_valid", rnd_valid, 1);
        check("t3_data", rnd_data, 8'hB2);
        run_en = 1'b0;
        rnd_ready = 1'b1;
        step();
        rnd_ready = 1'b0;
        check("t3_drained", rnd_valid, 0);

        // Test 4: stop with one buffered word and 5 partial bits
        send_bits(8'h3C, 8);
        send_bits(8'hF8, 5);
        check("t4_buf", rnd_data, 8'h3C);
        stop = 1'b1;
        step();
        stop = 1'b0;
        run_en = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_valid", rnd_valid, 0);
        check("t4_sready", seed_ready, 1);
        check("t4_start", core_start, 1);
        check("t4_ovf", ovf_count, 1);

        // Test 5: reset mid-warm-up, then identical latency on re-seed
        seed_x0 = 32'd5; seed_y0 = 32'd6; seed_p0 = 32'd7; seed_q0 = 32'd8;
        seed_valid = 1'b1;
        step();
        seed_valid = 1'b0;
        step();
        step();
        check("t5_in_warmup", core_start, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_start", core_start, 1);
        check("t5_sready", seed_ready, 1);
        check("t5_busy", busy, 0);
        check("t5_ovf", ovf_count, 0);
        check("t5_valid", rnd_valid, 0);
        check("t5_data", rnd_data, 8'h00);
        check("t5_seed", {core_x0, core_q0}, 64'd0);
        seed_and_warm(32'd1, 32'd2, 32'd3, 32'd4, "t5");
        send_bits(8'hA5, 7);
        check("t5_valid_t13", rnd_valid, 0);
        send_bits(8'hA5 << 7, 1);
        check("t5_valid_t14", rnd_valid, 1);
        check("t5_word", rnd_data, 8'hA5);

        // Test 6: full buffer, word completes on a pop cycle
        send_bits(8'h11, 8);
        send_bits(8'h22, 7);
        rnd_ready = 1'b1;
        core_zi = 1'b0;
        step();
        rnd_ready = 1'b0;
        run_en = 1'b0;
        check("t6_ovf", ovf_count, 0);
        check("t6_next", rnd_data, 8'h11);
        rnd_ready = 1'b1;
        step();
        check("t6_last", rnd_data, 8'h22);
        check("t6_last_v", rnd_valid, 1);
        step();
        check("t6_empty", rnd_valid, 0);
        step();
        check("t6_pop_empty", rnd_valid, 0);
        check("t6_ovf_end", ovf_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
